key_debounce: RTL
=================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter: DEBOUNCE, default 4, number of consecutive stable synchronized samples needed to accept a press or release; legal range 2..255.
REQ-002 SHALL have port: hz100  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: pb  input  20  raw, unsynchronized push-button levels; bit i = key code i.
REQ-005 SHALL have port: key  output  5  code (0..19) of the last accepted press; registered.
REQ-006 SHALL have port: strobe  output  1  high from press acceptance to release acceptance; registered, glitch-free, usable as a downstream clock.
REQ-007 SHALL have port: valid  output  1  one-cycle pulse marking each accepted press; registered.

Function
REQ-008 SHALL pass each pb bit through a 2-flop synchronizer; all later logic uses only the second-stage value s2.
REQ-009 SHALL derive any = OR of s2, and code = index of the highest set bit of s2 (0 if none).
REQ-010 SHALL implement states IDLE, PRESS_WAIT, HELD, REL_WAIT, with an 8-bit counter cnt and a 5-bit candidate register cand.
REQ-011 IDLE: if any, SHALL load cand=code, set cnt=1, and go to PRESS_WAIT; otherwise stay.
REQ-012 PRESS_WAIT: if !any, SHALL go to IDLE with cnt=0 (glitch rejected); if code!=cand, SHALL reload cand=code and set cnt=1 (restart).
REQ-013 PRESS_WAIT: if code==cand and cnt==DEBOUNCE-1, SHALL in the same edge set key=cand, set strobe=1, pulse valid=1, and go to HELD; otherwise SHALL increment cnt.
REQ-014 HELD: if !any, SHALL set cnt=1 and go to REL_WAIT; otherwise SHALL stay, ignore any code changes, and keep key unchanged.
REQ-015 REL_WAIT: if any, SHALL return to HELD with cnt=0 and keep strobe=1; if cnt==DEBOUNCE-1, SHALL clear strobe and go to IDLE; otherwise SHALL increment cnt.
REQ-016 Latency SHALL be exact: with pb stable from before edge E1, strobe and valid rise after edge E(DEBOUNCE+2) (edge 6 for DEBOUNCE=4). Release latency SHALL be the same.
REQ-017 valid SHALL be high for exactly one cycle per accepted press and never while HELD or REL_WAIT.
REQ-018 key SHALL hold its value through release and IDLE until the next accepted press.
REQ-019 Simultaneous keys SHALL resolve by highest index.
REQ-020 A press shorter than DEBOUNCE synchronized samples SHALL produce no strobe, no valid, and no key change.

Reset
REQ-021 reset SHALL asynchronously force state=IDLE, cnt=0, cand=0, synchronizer flops=0, key=0, strobe=0, valid=0.
REQ-022 Reset asserted in any state, including mid-debounce or HELD, SHALL discard progress; after deassertion, a full debounce SHALL be required, even if a key is still held.

Verification
REQ-023 Bench SHALL cover: DEBOUNCE=4, pb[5] high 12 cycles -> strobe and valid rise at edge 6, valid low at edge 7, key=5; strobe falls 6 edges after release.
REQ-024 Bench SHALL cover: pb[3] high 3 cycles then low -> strobe, valid, and key stay 0 throughout.
REQ-025 Bench SHALL cover: pb[16] and pb[2] rising on the same cycle -> key=16, single valid pulse.
REQ-026 Bench SHALL cover: pb[7] accepted, then pb[9] added while HELD -> key stays 7, no extra valid; release both -> strobe falls once.
REQ-027 Bench SHALL cover: while HELD on pb[4], pb drops for 2 cycles then returns -> strobe stays high, no new valid.
REQ-028 Bench SHALL cover: reset pulsed during PRESS_WAIT with pb[1] held -> all outputs 0 immediately; after deassertion, strobe rises DEBOUNCE+2 edges later with key=1.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button debouncer: 20 raw keys in, 5-bit code of the highest pressed key out,
// with a level strobe spanning press-to-release and a one-cycle valid per accepted press.
module key_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [19:0] pb,
    output logic [4:0]  key,
    output logic        strobe,
    output logic        valid
);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    localparam logic [7:0] LAST = 8'(DEBOUNCE - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [4:0]  cand, cand_n;
    logic [4:0]  key_n;
    logic        strobe_n, valid_n;
    logic [19:0] s1, s2;
    logic        any;
    logic [4:0]  code;

    // Two-flop synchronizer; nothing downstream may look at s1 or pb directly.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pb;
            s2 <= s1;
        end
    end

    // Highest set bit wins when several keys are down together.
    always_comb begin
        any  = |s2;
        code = '0;
        for (int i = 0; i < 20; i++)
            if (s2[i]) code = 5'(i);
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            cand   <= '0;
            key    <= '0;
            strobe <= 1'b0;
            valid  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            cand   <= cand_n;
            key    <= key_n;
            strobe <= strobe_n;
            valid  <= valid_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cand_n   = cand;
        key_n    = key;
        strobe_n = strobe;
        valid_n  = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    cand_n  = code;
                    cnt_n   = 8'd1;
                    state_n = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!any) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (code != cand) begin
                    cand_n = code;
                    cnt_n  = 8'd1;
                end else if (cnt == LAST) begin
                    key_n    = cand;
                    strobe_n = 1'b1;
                    valid_n  = 1'b1;
                    state_n  = HELD;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            HELD: begin
                // Code changes while held are deliberately ignored.
                if (!any) begin
                    cnt_n   = 8'd1;
                    state_n = REL_WAIT;
                end
            end
            REL_WAIT: begin
                if (any) begin
                    cnt_n   = '0;
                    state_n = HELD;
                end else if (cnt == LAST) begin
                    strobe_n = 1'b0;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
